// File: rtl/l1c_mem_arbiter.sv
// l1c_mem_arbiter: shares one memory port between the I-cache and D-cache.
// Serialises one request at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports:
//   clk, rst (async, active-low)
//   I_req/I_addr/I_write/I_in/I_type : I-cache request, held until done
//   D_req/D_addr/D_write/D_in/D_type : D-cache request, held until done
//   I_out/D_out   : registered returned word (shared)
//   I_wait/D_wait : requester stall, released in RESP for the owner
//   M_req         : one-cycle start pulse in ISSUE
//   M_addr/M_write/M_in/M_type : latched request fields
//   M_out/M_wait  : memory read data / memory busy
//
// Build option: define ARB_RR_EN for round-robin arbitration;
// otherwise D has fixed priority over I.
module l1c_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int TYPE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_req,
    input  logic [DATA_W-1:0] I_addr,
    input  logic              I_write,
    input  logic [DATA_W-1:0] I_in,
    input  logic [TYPE_W-1:0] I_type,
    output logic [DATA_W-1:0] I_out,
    output logic              I_wait,
    input  logic              D_req,
    input  logic [DATA_W-1:0] D_addr,
    input  logic              D_write,
    input  logic [DATA_W-1:0] D_in,
    input  logic [TYPE_W-1:0] D_type,
    output logic [DATA_W-1:0] D_out,
    output logic              D_wait,
    output logic              M_req,
    output logic [DATA_W-1:0] M_addr,
    output logic              M_write,
    output logic [DATA_W-1:0] M_in,
    output logic [TYPE_W-1:0] M_type,
    input  logic [DATA_W-1:0] M_out,
    input  logic              M_wait
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q;
    logic              owner_q;   // 0 = I, 1 = D
    logic              last_q;    // last completed owner
    logic [DATA_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] in_q;
    logic [TYPE_W-1:0] type_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mreq_q;
    logic              grant_d;   // 0 = I wins, 1 = D wins

`ifdef ARB_RR_EN
    // On a tie, favour whoever did not complete last.
    always_comb begin
        grant_d = D_req;
        if (I_req && D_req) begin
            grant_d = ~last_q;
        end
    end
`else
    always_comb begin
        grant_d = D_req;
    end

    // last_q is kept up to date but only steers the round-robin build.
    logic unused_last;
    assign unused_last = last_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            write_q <= 1'b0;
            in_q    <= '0;
            type_q  <= '0;
            rdata_q <= '0;
            mreq_q  <= 1'b0;
        end else begin
            mreq_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (I_req || D_req) begin
                        owner_q <= grant_d;
                        addr_q  <= grant_d ? D_addr  : I_addr;
                        write_q <= grant_d ? D_write : I_write;
                        in_q    <= grant_d ? D_in    : I_in;
                        type_q  <= grant_d ? D_type  : I_type;
                        mreq_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!M_wait) begin
                        rdata_q <= M_out;
                        last_q  <= owner_q;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic resp_i;
    logic resp_d;
    assign resp_i = (state_q == S_RESP) && !owner_q;
    assign resp_d = (state_q == S_RESP) && owner_q;

    assign I_wait  = I_req & ~resp_i;
    assign D_wait  = D_req & ~resp_d;
    assign I_out   = rdata_q;
    assign D_out   = rdata_q;
    assign M_req   = mreq_q;
    assign M_addr  = addr_q;
    assign M_write = write_q;
    assign M_in    = in_q;
    assign M_type  = type_q;

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// tb_l1c_mem_arbiter: random requesters and memory against a
// transaction/timestamp reference model of the arbiter.
module tb_l1c_mem_arbiter;

    localparam int DW = 32;
    localparam int TW = 3;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0;
    logic [DW-1:0] i_addr = '0, d_addr = '0;
    logic          i_write = 1'b0, d_write = 1'b0;
    logic [DW-1:0] i_in = '0, d_in = '0;
    logic [TW-1:0] i_type = '0, d_type = '0;
    logic [DW-1:0] i_out, d_out;
    logic          i_wait, d_wait;
    logic          m_req;
    logic [DW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_in;
    logic [TW-1:0] m_type;
    logic [DW-1:0] m_out = '0;
    logic          m_wait = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l1c_mem_arbiter #(.DATA_W(DW), .TYPE_W(TW)) dut (
        .clk(clk), .rst(rst),
        .I_req(i_req), .I_addr(i_addr), .I_write(i_write),
        .I_in(i_in), .I_type(i_type), .I_out(i_out), .I_wait(i_wait),
        .D_req(d_req), .D_addr(d_addr), .D_write(d_write),
        .D_in(d_in), .D_type(d_type), .D_out(d_out), .D_wait(d_wait),
        .M_req(m_req), .M_addr(m_addr), .M_write(m_write),
        .M_in(m_in), .M_type(m_type), .M_out(m_out), .M_wait(m_wait)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: an accepted transaction is described by who owns it,
    // what was latched, the cycle of its start pulse and its response cycle.
    bit            busy;
    bit            owner;      // 0 = I, 1 = D
    bit            last;
    bit            returned;
    int            issue_c;
    int            resp_c;
    logic [DW-1:0] l_addr, l_in, rdata;
    logic          l_write;
    logic [TW-1:0] l_type;
    bit            i_done, d_done;

    task automatic model_reset();
        busy = 0; owner = 0; last = 1; returned = 0;
        issue_c = -10; resp_c = -10;
        l_addr = '0; l_in = '0; l_write = 0; l_type = '0; rdata = '0;
    endtask

    function automatic bit pick_d(bit ir, bit dr, bit lst);
`ifdef ARB_RR_EN
        if (ir && dr) return !lst;
        return dr;
`else
        return dr;
`endif
    endfunction

    initial begin
        bit exp_iw, exp_dw, exp_mreq, g;
        model_reset();
        i_done = 0; d_done = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // step 1: drive this cycle's inputs
            rst = (c < 2) ? 1'b0 : (($urandom % 250) != 0);
            if (!rst) model_reset();
            if (i_done) begin i_req = 0; i_done = 0; end
            else if (i_req && ($urandom % 40) == 0) i_req = 0;
            else if (i_req && ($urandom % 8) == 0) i_addr = $urandom;
            if (!i_req && ($urandom % 2) == 0) begin
                i_req = 1; i_addr = $urandom; i_write = $urandom;
                i_in = $urandom; i_type = TW'($urandom);
            end
            if (d_done) begin d_req = 0; d_done = 0; end
            else if (d_req && ($urandom % 40) == 0) d_req = 0;
            else if (d_req && ($urandom % 8) == 0) d_in = $urandom;
            if (!d_req && ($urandom % 2) == 0) begin
                d_req = 1; d_addr = $urandom; d_write = $urandom;
                d_in = $urandom; d_type = TW'($urandom);
            end
            m_wait = ($urandom % 5) < 2;
            m_out = $urandom;

            // step 2: check outputs of this cycle
            @(negedge clk);
            exp_mreq = busy && (c == issue_c);
            exp_iw = i_req && !(busy && c == resp_c && owner == 0);
            exp_dw = d_req && !(busy && c == resp_c && owner == 1);
            chk("M_req", 32'(m_req), 32'(exp_mreq));
            chk("M_addr", m_addr, l_addr);
            chk("M_write", 32'(m_write), 32'(l_write));
            chk("M_in", m_in, l_in);
            chk("M_type", 32'(m_type), 32'(l_type));
            chk("I_wait", 32'(i_wait), 32'(exp_iw));
            chk("D_wait", 32'(d_wait), 32'(exp_dw));
            chk("I_out", i_out, rdata);
            chk("D_out", d_out, rdata);
            i_done = i_req && !exp_iw;
            d_done = d_req && !exp_dw;

            // step 3: advance the model with this cycle's inputs
            if (rst) begin
                if (!busy) begin
                    if (i_req || d_req) begin
                        g = pick_d(i_req, d_req, last);
                        busy = 1; owner = g; returned = 0;
                        issue_c = c + 1; resp_c = -10;
                        l_addr  = g ? d_addr  : i_addr;
                        l_write = g ? d_write : i_write;
                        l_in    = g ? d_in    : i_in;
                        l_type  = g ? d_type  : i_type;
                    end
                end else if (c == resp_c) begin
                    busy = 0;
                end else if (c > issue_c && !returned && !m_wait) begin
                    returned = 1; rdata = m_out; last = owner;
                    resp_c = c + 1;
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/l1c_mem_arbiter.md
# l1c_mem_arbiter

Shares a single memory-side port between the instruction cache (L1C_inst) and the data cache (L1C_data) inside the CPU wrapper. Each cache presents its miss/refill or write-through request as `req`/`addr`/`write`/`in`/`type`. The arbiter serialises these requests onto one downstream port and routes the returned word and completion back to the owning cache. At most one transaction is in flight; there is no buffering beyond one latched request.

## Interface
- `DATA_W`, default 32 (`DATA_BITS`): width of address and data.
- `TYPE_W`, default 3 (`CACHE_TYPE_BITS`): width of the access type.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `I_req`, `D_req` in 1: request from the I-cache / D-cache, held until completion.
- `I_addr`, `D_addr` in DATA_W: request address.
- `I_write`, `D_write` in 1: 1 means write, 0 means read.
- `I_in`, `D_in` in DATA_W: write data.
- `I_type`, `D_type` in TYPE_W: access type.
- `I_out`, `D_out` out DATA_W: returned read word; the same registered value drives both.
- `I_wait`, `D_wait` out 1: requester stall.
- `M_req` out 1: one-cycle start pulse to memory.
- `M_addr` out DATA_W: latched request address.
- `M_write` out 1: latched write flag.
- `M_in` out DATA_W: latched write data.
- `M_type` out TYPE_W: latched access type.
- `M_out` in DATA_W: memory read data, valid in the cycle `M_wait` is low during WAIT.
- `M_wait` in 1: memory busy.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Registers:
  - `owner`: 0 = I, 1 = D.
  - `last`: last granted requester.
  - Latched `addr`/`write`/`in`/`type`.
  - `rdata`.
- IDLE:
  - If `I_req | D_req`, select a winner and latch its fields and `owner`, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `M_req` = 1 for exactly this cycle.
  - Go to WAIT unconditionally.
- WAIT:
  - If `M_wait` = 0, capture `M_out` into `rdata`, update `last` to `owner`, and go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - The owner's `wait` = 0 for this cycle.
  - `I_out`/`D_out` = `rdata`.
  - Go to IDLE.
- `X_wait` = `X_req` & ~(state == RESP & owner == X). This is combinational from state and `req`.
- Write transactions follow the same sequence. `rdata` still captures `M_out`, and requesters ignore it.
- `M_addr`/`M_write`/`M_in`/`M_type` drive the latched registers continuously. They stay stable from ISSUE through RESP.
- A requester dropping `req` mid-transaction does not abort it: the memory access completes, RESP is spent, and no `wait` is released to anyone.
- A requester changing `addr` while `req` is held has no effect on the latched transaction.
- The non-owner requesting during a transaction sees `wait` = 1 until it is granted and completes.

## Timing
- Reset values:
  - state = IDLE, `owner` = 0, `last` = 1.
  - All latched fields and `rdata` = 0.
  - `M_req` = 0.
  - `I_out` = `D_out` = 0.
  - `I_wait` = `I_req`, `D_wait` = `D_req`.
- Reset mid-transaction returns to IDLE immediately and abandons the memory access; memory is responsible for its own reset.
- Minimum latency: `req` sampled in IDLE at cycle 0, ISSUE at cycle 1, WAIT at cycle 2 with `M_wait` = 0, RESP at cycle 3. The requester sees `wait` = 0 at cycle 3.
- Each extra `M_wait` = 1 cycle in WAIT adds one cycle.
- Back-to-back: a requester still holding `req` after RESP is re-arbitrated in the following IDLE cycle. Minimum spacing between two `M_req` pulses is 4 cycles.
- `M_wait` is ignored in IDLE, ISSUE and RESP.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request, the grant goes to the requester ≠ `last`.
  - A single request is always granted.
- `ARB_RR_EN` undefined: fixed priority, D over I. I is granted only when `D_req` = 0 in IDLE.
  - `last` is still maintained but unused.

## Test plan
- Single I read, addr 0x0000_0100, memory holds `M_wait` for 2 cycles in WAIT then returns 0xDEAD_BEEF → `M_req` pulse at cycle 1, `M_addr` = 0x100, `I_wait` low at cycle 5 only, `I_out` = 0xDEAD_BEEF, `D_wait` untouched.
- Simultaneous I read 0x40 and D write 0x80/0x1234_5678, zero-wait memory:
  - Without `ARB_RR_EN`: D is served first (`M_write` = 1, `M_in` = 0x1234_5678, `D_wait` low at cycle 3), then I (`I_wait` low at cycle 7).
  - With `ARB_RR_EN`, after reset (`last` = 1): I is served first, then D.
- `ARB_RR_EN`, both requests held continuously for 4 transactions → grant order I, D, I, D, with `M_req` pulses at cycles 1, 5, 9, 13.
- `I_req` dropped during WAIT → memory access still completes, state passes through RESP, `I_wait`/`D_wait` stay 0/`D_req`, and the next IDLE grants D if pending.
- `rst` asserted low for 1 cycle during WAIT → state goes to IDLE, `M_req` = 0, `I_out` = 0, and a held `I_req` re-issues with an `M_req` pulse 1 cycle after reset release.
